// File: rtl/proc_boot_ctrl.sv
// Program-load and run controller: streams a program into imem,
// holds the core in reset, runs it, and reports how the run ended.
module proc_boot_ctrl #(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int CNT_W = 16,
  parameter int RST_HOLD = 4,
  parameter int FILL_NOP = 1,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013),
  localparam int ADDR_W = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [XLEN-1:0]   imem_wdata,
  input  logic              core_halt,
  output logic              core_resetn,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CNT_W-1:0]  cycles_used
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMEM_DEPTH - 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [HW-1:0]     hcnt;
  logic [CNT_W-1:0]  budget;
  logic [CNT_W:0]    cnt_inc;
  logic              hs;
  logic              expire;

  assign ld_ready = (state == S_LOAD);
  assign hs = ld_valid & ld_ready;
  assign cnt_inc = {1'b0, cycles_used} + {{CNT_W{1'b0}}, 1'b1};
  assign expire = (budget != '0) && (cnt_inc == {1'b0, budget});

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wptr         <= '0;
      hcnt         <= '0;
      budget       <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_resetn  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      cycles_used  <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            state        <= S_LOAD;
            budget       <= run_cycles;
            wptr         <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            halted       <= 1'b0;
            timeout      <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            cycles_used  <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            imem_we      <= 1'b1;
            imem_waddr   <= wptr;
            imem_wdata   <= ld_data;
            wptr         <= wptr + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            if (ld_last || wptr == LAST) begin
              load_err <= !ld_last;
              hcnt     <= HOLD_INIT;
              if (FILL_NOP != 0 && wptr < LAST)
                state <= S_FILL;
              else
                state <= S_HOLD;
            end
          end
        end
        S_FILL: begin
          imem_we    <= 1'b1;
          imem_waddr <= wptr;
          imem_wdata <= NOP_WORD;
          wptr       <= wptr + ADDR_W'(1);
          if (wptr == LAST)
            state <= S_HOLD;
        end
        S_HOLD: begin
          if (hcnt == '0) begin
            state       <= S_RUN;
            core_resetn <= 1'b1;
          end else begin
            hcnt <= hcnt - HW'(1);
          end
        end
        S_RUN: begin
          if (!cnt_inc[CNT_W])
            cycles_used <= cnt_inc[CNT_W-1:0];
          // halt wins over a budget expiring in the same cycle
          if (core_halt || expire) begin
            state       <= S_DONE;
            core_resetn <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            halted      <= core_halt;
            timeout     <= !core_halt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_boot_ctrl.sv
// Bench for proc_boot_ctrl: three configurations driven from a
// scenario table, with a write scoreboard and reset sequences.
module tb_proc_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ls[3], lv[3], ll[3], halt[3];
  logic [15:0] rc[3];
  logic [31:0] ld[3];
  logic        rdy[3], we[3], crn[3], busy[3], done[3];
  logic        hlt[3], to[3], err[3];
  logic [5:0]  wa[3];
  logic [31:0] wd[3];
  logic [6:0]  wl[3];
  logic [15:0] cu[3];

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int D = (g == 0) ? 64 : ((g == 1) ? 16 : 8);
    localparam int AW = $clog2(D);
    logic [AW-1:0] wa_n;
    logic [AW:0]   wl_n;
    proc_boot_ctrl #(
      .IMEM_DEPTH(D),
      .FILL_NOP((g == 1) ? 1 : 0),
      .RST_HOLD(4)
    ) dut (
      .clk(clk),
      .reset(reset),
      .load_start(ls[g]),
      .run_cycles(rc[g]),
      .ld_valid(lv[g]),
      .ld_ready(rdy[g]),
      .ld_data(ld[g]),
      .ld_last(ll[g]),
      .imem_we(we[g]),
      .imem_waddr(wa_n),
      .imem_wdata(wd[g]),
      .core_halt(halt[g]),
      .core_resetn(crn[g]),
      .busy(busy[g]),
      .done(done[g]),
      .halted(hlt[g]),
      .timeout(to[g]),
      .load_err(err[g]),
      .words_loaded(wl_n),
      .cycles_used(cu[g])
    );
    assign wa[g] = 6'(wa_n);
    assign wl[g] = 7'(wl_n);
  end

  typedef struct {
    int          a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int g;
    int n;
    bit last;
    bit gaps;
    int budget;
    int halt_at;
    bit ls_run;
    int exp_len;
    bit exp_h;
    bit exp_t;
    int exp_wl;
    bit exp_err;
  } scn_t;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int HOLD = 4;

  logic [31:0] prog[6] = '{32'h01908093, 32'h04b10113, 32'h002080b3,
                           32'h40208133, 32'h402080b3, 32'hffd08093};

  wr_t  q[$];
  scn_t tbl[8];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   cur = 0;
  int   last_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dep(int g);
    return (g == 0) ? 64 : ((g == 1) ? 16 : 8);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (we[cur] === 1'b1) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL wr_extra: got write %0d/%h, expected none",
                 wa[cur], wd[cur]);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(wa[cur]), 64'(e.a));
        chk("wr_data", 64'(wd[cur]), 64'(e.d));
        last_wr = cyc;
      end
    end
  end

  task automatic chk_rst(int g);
    chk("rst_ctl", 64'({rdy[g], we[g], crn[g], busy[g], done[g],
                        hlt[g], to[g], err[g]}), 64'(0));
    chk("rst_cnt", 64'({wa[g], wl[g], cu[g]}), 64'(0));
    chk("rst_wdata", 64'(wd[g]), 64'(0));
  endtask

  task automatic do_load(int g, int n, bit last, bit gaps, int budget);
    int k;
    int sent;
    bit inload;
    logic [31:0] w;
    cur = g;
    ls[g] = 1'b1;
    rc[g] = 16'(budget);
    step();
    ls[g] = 1'b0;
    chk("start", 64'({busy[g], done[g], hlt[g], to[g], err[g], wl[g], cu[g]}),
        64'({1'b1, 4'b0, 7'd0, 16'd0}));
    k = 0;
    sent = 0;
    inload = 1'b1;
    while (sent < n) begin
      w = (sent < 6) ? prog[sent] : $urandom;
      if (inload && gaps && $urandom_range(0, 2) == 0) begin
        lv[g] = 1'b0;
        ll[g] = 1'b0;
      end else begin
        lv[g] = 1'b1;
        ld[g] = w;
        ll[g] = last && (sent == n - 1);
      end
      chk("ready", 64'(rdy[g]), 64'(inload));
      if (lv[g]) begin
        if (inload) begin
          q.push_back('{k, w});
          k++;
          if (ll[g] || k == dep(g)) inload = 1'b0;
        end
        sent++;
      end
      step();
    end
    lv[g] = 1'b0;
    ll[g] = 1'b0;
    if (g == 1)
      for (int a = k; a < dep(g); a++) q.push_back('{a, NOP});
  endtask

  task automatic run_scn(scn_t s);
    int g;
    int t;
    int runlen;
    g = s.g;
    do_load(g, s.n, s.last, s.gaps, s.budget);
    t = 0;
    while (q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    chk("wr_pending", 64'(q.size()), 64'(0));
    t = 0;
    while (crn[g] !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk("hold_len", 64'(cyc - last_wr), 64'(HOLD));
    runlen = 0;
    while (crn[g] === 1'b1 && runlen < 1000) begin
      runlen++;
      halt[g] = (runlen == s.halt_at);
      if (s.ls_run) begin
        ls[g] = (runlen == 2);
        rc[g] = 16'd1;
      end
      step();
    end
    halt[g] = 1'b0;
    ls[g] = 1'b0;
    chk("run_len", 64'(runlen), 64'(s.exp_len));
    chk("end_flags", 64'({done[g], busy[g], crn[g], hlt[g], to[g], err[g]}),
        64'({3'b100, s.exp_h, s.exp_t, s.exp_err}));
    chk("cycles_used", 64'(cu[g]), 64'(s.exp_len));
    chk("words_loaded", 64'(wl[g]), 64'(s.exp_wl));
    halt[g] = 1'b1;
    step();
    step();
    halt[g] = 1'b0;
    chk("done_hold", 64'({done[g], hlt[g], to[g], cu[g]}),
        64'({1'b1, s.exp_h, s.exp_t, 16'(s.exp_len)}));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    tbl[0] = '{0, 6, 1, 0, 20, 0, 0, 20, 0, 1, 6, 0};
    tbl[1] = '{1, 6, 1, 1, 20, 0, 0, 20, 0, 1, 6, 0};
    tbl[2] = '{0, 6, 1, 1, 0, 9, 0, 9, 1, 0, 6, 0};
    tbl[3] = '{0, 6, 1, 0, 5, 5, 0, 5, 1, 0, 6, 0};
    tbl[4] = '{2, 10, 0, 0, 3, 0, 0, 3, 0, 1, 8, 1};
    tbl[5] = '{2, 8, 1, 1, 1, 0, 0, 1, 0, 1, 8, 0};
    tbl[6] = '{1, 16, 1, 1, 2, 0, 0, 2, 0, 1, 16, 0};
    tbl[7] = '{0, 6, 1, 0, 7, 3, 1, 3, 1, 0, 6, 0};

    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      ls[g] = 1'b0;
      lv[g] = 1'b0;
      ll[g] = 1'b0;
      halt[g] = 1'b0;
      rc[g] = '0;
      ld[g] = '0;
    end
    step();
    step();
    for (int g = 0; g < 3; g++) chk_rst(g);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_scn(tbl[i]);

    // reset in the middle of a load
    do_load(0, 3, 1'b0, 1'b0, 10);
    reset = 1'b1;
    step();
    chk_rst(0);
    reset = 1'b0;
    q.delete();
    step();

    // reset in the middle of a run
    do_load(0, 6, 1'b1, 1'b0, 0);
    t = 0;
    while (crn[0] !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk("mid_run", 64'(crn[0]), 64'(1));
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk_rst(0);
    reset = 1'b0;
    q.delete();
    step();

    run_scn(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
